bfm_src: RTL
============

Name: bfm_src

Overview:
- Stimulus source BFM that feeds 128-bit test vectors into the DUT input stream, using the same valid/ready handshake that the checker BFM observes on the DUT output.
- Vectors are preloaded into an internal memory, then replayed on a start command.
- Supports a programmable start delay, programmable idle gaps between beats, and correct hold-under-backpressure.
- Supplies the DUT input side of the AES testbench; its pass/fail counterpart sits on the DUT output.

Parameters:
- NAME, "Source": instance label printed in $display messages.
- MEM_SIZE, 100: vector memory depth, in 128-bit entries.
- GAP_W, 8: width of the inter-beat gap configuration.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  memory write strobe.
- wr_addr  input  32  memory write address; ignored if >= MEM_SIZE.
- wr_data  input  128  memory write data.
- cfg_length  input  32  number of beats to send.
- cfg_gap  input  GAP_W  idle cycles inserted after each accepted beat.
- start  input  1  one-cycle start request.
- start_wait  input  32  cycles to wait before the first beat.
- tx_data  output  128  stream data.
- tx_vld  output  1  stream valid.
- tx_rdy  input  1  stream ready from DUT.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a run completes.
- cnt_tx  output  32  beats accepted in the current or last run.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; reset is rst, synchronous and active-high.
- Reset values: state=IDLE, tx_vld=0, tx_data=0, busy=0, done=0, cnt_tx=0, idx=0, wait/gap counters=0.
- Memory contents are not reset; they are initialised to 0 at time zero only.
- Memory write: on rising edge with wr_en=1 and wr_addr<MEM_SIZE, mem[wr_addr]<=wr_data. Writes are accepted in any state. A beat already presented keeps its value, because tx_data is registered.
- States:
  - IDLE
  - WAIT: start delay.
  - SEND: tx_vld=1.
  - GAP: tx_vld=0.
- IDLE:
  - start=1 latches cfg_length, cfg_gap and start_wait, and clears idx, cnt_tx and the counters.
  - If cfg_length==0: done=1 next cycle, stay IDLE, never assert tx_vld.
  - Else if start_wait==0: go to SEND; tx_vld=1 and tx_data=mem[0] in the cycle after start is sampled.
  - Else go to WAIT.
  - start is ignored in every state other than IDLE.
- WAIT:
  - wait counter increments each cycle.
  - When counter==start_wait-1: load tx_data=mem[0], go to SEND. First beat appears start_wait+1 cycles after start is sampled.
- SEND:
  - tx_vld=1.
  - While tx_rdy=0, tx_data and tx_vld hold stable.
  - On tx_vld&&tx_rdy: cnt_tx++, idx++.
  - If cnt_tx+1==length: tx_vld=0, done=1 for one cycle, go to IDLE.
  - Else if gap==0: load mem[idx+1] and stay in SEND (back-to-back beats).
  - Else go to GAP with tx_vld=0.
- GAP: gap counter counts; at gap-1, load mem[idx] and go to SEND.
- Index wrap: idx wraps to 0 at MEM_SIZE, so a length greater than MEM_SIZE replays the memory cyclically. cnt_tx is 32-bit and is not wrapped.
- Reset mid-run: return to IDLE next edge and drop tx_vld. A beat in flight is abandoned and done is not pulsed. A later start begins again from mem[0].
- Reset wins over start in the same cycle.
- Messages:
  - If NAME is set, display on each accepted beat: time, idx, data.
  - Display "DONE" on completion.

Decomposition:
- Shared package/include: state encodings ST_IDLE/ST_WAIT/ST_SEND/ST_GAP (2-bit), shared with the checker BFM's style of localparams; 128-bit data width constant.
- Sub-module bfm_vec_mem: MEM_SIZE x 128, one synchronous write port, one asynchronous read port, with out-of-range write masking.
- FSM, counters and output registers stay in bfm_src.

Test Plan:
- Back-to-back run: mem[0..3]=128'h1..128'h4, length=4, gap=0, wait=0, tx_rdy=1, start at cycle T -> tx_vld high T+1..T+4 with data 1,2,3,4; done at T+5; cnt_tx=4; busy low after.
- Start delay: same setup with start_wait=5 -> first tx_vld at T+6; data sequence unchanged.
- Gap insertion: gap=2, length=3 -> tx_vld pattern 1,0,0,1,0,0,1, then done; no data skipped.
- Backpressure: tx_rdy=0 for 3 cycles during beat 1 -> tx_data=128'h2 held stable while tx_vld=1; no duplicate or skipped beat; cnt_tx=4 at end. Also write mem[1] during the hold -> held data unchanged.
- Edge cases:
  - length=0 -> done pulse, tx_vld never rises.
  - start asserted while busy -> ignored, run unchanged.
  - length=MEM_SIZE+2 -> last two beats are mem[0], mem[1].
- Reset mid-run: rst during beat 2 of 4 -> tx_vld=0 next cycle, no done, cnt_tx=0. A new start replays from mem[0] with memory contents intact.

Source files
------------

// File: rtl/bfm_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bfm_src_pkg
// Brief    : Shared types and constants for the stimulus source BFM.
// Revision : 1.0 - initial release
// ============================================================================
package bfm_src_pkg;

    localparam int unsigned c_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Address width for a memory of the given depth, never narrower than 1 bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfm_src_if.sv
`default_nettype none
// ============================================================================
// Module   : bfm_src_if
// Brief    : 128-bit valid/ready stream between the source BFM and the DUT.
// Revision : 1.0 - initial release
// ============================================================================
interface bfm_src_if;
    import bfm_src_pkg::*;

    logic [c_DATA_W-1:0] tx_data;
    logic                tx_vld;
    logic                tx_rdy;

    modport master (output tx_data, output tx_vld, input tx_rdy);
    modport slave  (input tx_data, input tx_vld, output tx_rdy);

endinterface
`default_nettype wire

// File: rtl/bfm_vec_mem.sv
`default_nettype none
// ============================================================================
// Module   : bfm_vec_mem
// Brief    : Vector store, one synchronous write port and one asynchronous
//            read port; writes outside the memory depth are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_vec_mem
    import bfm_src_pkg::*;
#(
    parameter int          MEM_SIZE = 100,
    parameter int unsigned ADDR_W   = addr_width(MEM_SIZE)
) (
    input  wire                 clk,
    input  wire                 wr_en,
    input  wire [31:0]          wr_addr,
    input  wire [c_DATA_W-1:0]  wr_data,
    input  wire [ADDR_W-1:0]    rd_addr,
    output logic [c_DATA_W-1:0] rd_data
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [c_DATA_W-1:0] r_mem [MEM_SIZE] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < 32'(MEM_SIZE))) begin
            r_mem[wr_addr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/bfm_src.sv
`default_nettype none
// ============================================================================
// Module   : bfm_src
// Brief    : Stimulus source BFM; replays preloaded vectors on a valid/ready
//            stream with programmable start delay and inter-beat gaps.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_src
    import bfm_src_pkg::*;
#(
    parameter int MEM_SIZE = 100,
    parameter int GAP_W    = 8
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 wr_en,
    input  wire [31:0]          wr_addr,
    input  wire [c_DATA_W-1:0]  wr_data,
    input  wire [31:0]          cfg_length,
    input  wire [GAP_W-1:0]     cfg_gap,
    input  wire                 start,
    input  wire [31:0]          start_wait,
    bfm_src_if.master           tx,
    output logic                busy,
    output logic                done,
    output logic [31:0]         cnt_tx
);

    localparam int unsigned c_AW = addr_width(MEM_SIZE);

    state_t              r_state,    w_state;
    logic                r_vld,      w_vld;
    logic [c_DATA_W-1:0] r_data,     w_data;
    logic                r_done,     w_done;
    logic [31:0]         r_cnt,      w_cnt;
    logic [c_AW-1:0]     r_idx,      w_idx;
    logic [31:0]         r_len,      w_len;
    logic [31:0]         r_wait,     w_wait;
    logic [31:0]         r_wait_cnt, w_wait_cnt;
    logic [GAP_W-1:0]    r_gap,      w_gap;
    logic [GAP_W-1:0]    r_gap_cnt,  w_gap_cnt;
    logic [c_AW-1:0]     w_idx_inc;
    logic [c_AW-1:0]     w_rd_addr;
    logic [c_DATA_W-1:0] w_rd_data;

    bfm_vec_mem #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (c_AW)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (w_rd_addr),
        .rd_data  (w_rd_data)
    );

    // Replay index wraps so lengths beyond MEM_SIZE cycle through memory.
    assign w_idx_inc = (r_idx == c_AW'(MEM_SIZE - 1)) ? '0 : r_idx + c_AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vld      <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_wait     <= '0;
            r_wait_cnt <= '0;
            r_gap      <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state;
            r_vld      <= w_vld;
            r_data     <= w_data;
            r_done     <= w_done;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_len      <= w_len;
            r_wait     <= w_wait;
            r_wait_cnt <= w_wait_cnt;
            r_gap      <= w_gap;
            r_gap_cnt  <= w_gap_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_vld      = r_vld;
        w_data     = r_data;
        w_done     = 1'b0;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_len      = r_len;
        w_wait     = r_wait;
        w_wait_cnt = r_wait_cnt;
        w_gap      = r_gap;
        w_gap_cnt  = r_gap_cnt;
        w_rd_addr  = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_len      = cfg_length;
                    w_gap      = cfg_gap;
                    w_wait     = start_wait;
                    w_idx      = '0;
                    w_cnt      = '0;
                    w_wait_cnt = '0;
                    w_gap_cnt  = '0;
                    if (cfg_length == '0) begin
                        w_done = 1'b1;
                    end else if (start_wait == '0) begin
                        w_state = ST_SEND;
                        w_vld   = 1'b1;
                        w_data  = w_rd_data;
                    end else begin
                        w_state = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (r_wait_cnt == r_wait - 32'd1) begin
                    w_state = ST_SEND;
                    w_vld   = 1'b1;
                    w_data  = w_rd_data;
                end else begin
                    w_wait_cnt = r_wait_cnt + 32'd1;
                end
            end

            ST_SEND: begin
                // Prefetch the following entry so back-to-back beats need no bubble.
                w_rd_addr = w_idx_inc;
                if (r_vld && tx.tx_rdy) begin
                    w_cnt = r_cnt + 32'd1;
                    w_idx = w_idx_inc;
                    if (r_cnt + 32'd1 == r_len) begin
                        w_state = ST_IDLE;
                        w_vld   = 1'b0;
                        w_done  = 1'b1;
                    end else if (r_gap == '0) begin
                        w_data = w_rd_data;
                    end else begin
                        w_state   = ST_GAP;
                        w_vld     = 1'b0;
                        w_gap_cnt = '0;
                    end
                end
            end

            ST_GAP: begin
                w_rd_addr = r_idx;
                if (r_gap_cnt == r_gap - GAP_W'(1)) begin
                    w_state = ST_SEND;
                    w_vld   = 1'b1;
                    w_data  = w_rd_data;
                end else begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_vld   = 1'b0;
            end
        endcase
    end

    assign tx.tx_data = r_data;
    assign tx.tx_vld  = r_vld;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign cnt_tx     = r_cnt;

endmodule
`default_nettype wire
